// File: rtl/ifm_gearbox.sv
// ifm_gearbox: converts IN_W-bit input words to OUT_W-bit output words (LSB first)
// for a frame of a programmed number of output words. Both sides use valid/ready.
// Optional feature macro: IFM_GB_OREG_EN inserts a 2-entry skid register slice
// on the output (m_data/m_valid come straight from flops, +1 cycle latency).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start_conv_pulse; buffer empty
// RUN   | frame in progress: accept input words, emit output words
// DONE  | single-cycle frame end: done pulse, buffer and fill cleared
module ifm_gearbox #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 80,
    parameter int BUF_W = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_conv_pulse,
    input  logic [CNT_W-1:0] cfg_out_words,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int IBL_W  = CNT_W + $clog2(OUT_W);

    localparam logic [FILL_W-1:0] IN_STEP   = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] OUT_STEP  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] PUSH_MAX  = FILL_W'(BUF_W - IN_W);
    localparam logic [IBL_W-1:0]  IN_BITS   = IBL_W'(IN_W);
    localparam logic [IBL_W-1:0]  OUT_BITS  = IBL_W'(OUT_W);

    // A buffer smaller than one input plus one output word could deadlock.
    generate
        if (BUF_W < IN_W + OUT_W) begin : g_buf_check
            $error("ifm_gearbox: BUF_W must be >= IN_W + OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [BUF_W-1:0]  buf_shifted;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] push_pos;
    logic [CNT_W-1:0]  out_left_q, out_left_d;
    logic [IBL_W-1:0]  ibl_q, ibl_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, done_q;

    logic              push, pop;
    logic              src_valid, src_ready;
    logic [OUT_W-1:0]  src_data;
    logic              drain_done;

    // The low OUT_W bits of the buffer form the next output word.
    assign src_valid = (state_q == RUN) && (fill_q >= OUT_STEP) && (out_left_q != '0);
    assign src_data  = buf_q[OUT_W-1:0];
    assign pop       = src_valid && src_ready;
    assign push      = s_valid && s_ready_q;

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef IFM_GB_OREG_EN
    logic [OUT_W-1:0] m_data_q, sk_data_q;
    logic             m_valid_q, sk_valid_q;

    // Ready toward the buffer is a flop, so the slice never passes m_ready through.
    assign src_ready  = !sk_valid_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign drain_done = (out_left_q == '0) && !m_valid_q && !sk_valid_q;

    // Two-entry skid slice: output register backed by one overflow entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            sk_data_q  <= '0;
            sk_valid_q <= 1'b0;
        end else if (!m_valid_q || m_ready) begin
            if (sk_valid_q) begin
                m_data_q   <= sk_data_q;
                m_valid_q  <= 1'b1;
                sk_valid_q <= 1'b0;
            end else begin
                m_valid_q <= pop;
                if (pop) begin
                    m_data_q <= src_data;
                end
            end
        end else if (pop) begin
            sk_data_q  <= src_data;
            sk_valid_q <= 1'b1;
        end
    end
`else
    assign src_ready  = m_ready;
    assign m_data     = src_data;
    assign m_valid    = src_valid;
    assign drain_done = pop && (out_left_q == CNT_W'(1));
`endif

    // Next-state, buffer update and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_shifted = buf_q;
        push_pos    = fill_q;
        fill_d      = fill_q;
        out_left_d  = out_left_q;
        ibl_d       = ibl_q;

        case (state_q)
            IDLE: begin
                if (start_conv_pulse) begin
                    buf_d  = '0;
                    fill_d = '0;
                    if (cfg_out_words != '0) begin
                        out_left_d = cfg_out_words;
                        ibl_d      = IBL_W'(cfg_out_words) * OUT_BITS;
                        state_d    = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // With a simultaneous pop the write lands OUT_W lower, since the
                // buffer shifts right in the same cycle.
                if (pop) begin
                    buf_shifted = buf_q >> OUT_W;
                    push_pos    = fill_q - OUT_STEP;
                    out_left_d  = out_left_q - CNT_W'(1);
                end
                buf_d = buf_shifted;
                if (push) begin
                    buf_d = buf_shifted | (BUF_W'(s_data) << push_pos);
                    ibl_d = (ibl_q > IN_BITS) ? (ibl_q - IN_BITS) : '0;
                end
                fill_d = fill_q + (push ? IN_STEP : '0) - (pop ? OUT_STEP : '0);
                if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Residual bits of the last input word are dropped here.
                buf_d   = '0;
                fill_d  = '0;
                state_d = IDLE;
            end
            default: begin
                buf_d   = '0;
                fill_d  = '0;
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == RUN) && (ibl_d != '0) && (fill_d <= PUSH_MAX);
    end

    // State, buffer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            out_left_q <= '0;
            ibl_q      <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            out_left_q <= out_left_d;
            ibl_q      <= ibl_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

endmodule

// File: doc/ifm_gearbox.md
# ifm_gearbox

Parametrised input-feature-map width converter for the conv accelerator. It sits between the AXI-stream IFM read path and the PE array feed. It accepts IN_W-bit words under valid/ready and emits OUT_W-bit words LSB-first under valid/ready, for a frame of a programmed number of output words. Any IN_W/OUT_W ratio is supported, and both sides are back-pressured, replacing the fixed 512→80, five-register, request-driven parser.

## Interface
- IN_W, 512: input word width (bits).
- OUT_W, 80: output word width (bits).
- BUF_W, 1024: bit-buffer capacity. Constraint BUF_W ≥ IN_W + OUT_W, checked at elaboration.
- CNT_W, 16: width of frame word counter.
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_conv_pulse  in  1  one-cycle frame start; latches cfg_out_words.
- cfg_out_words  in  CNT_W  output words in the frame.
- s_data  in  IN_W  input word.
- s_valid  in  1  input valid.
- s_ready  out  1  input ready.
- m_data  out  OUT_W  output word.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

## Operation
- **State machine:** IDLE → RUN → DONE → IDLE.
- **IDLE**
  - start_conv_pulse with cfg_out_words ≠ 0: latch out_left = cfg_out_words and in_bits_left = cfg_out_words·OUT_W (width CNT_W + clog2(OUT_W)), clear buffer, go to RUN.
  - cfg_out_words = 0: go straight to DONE.
- **RUN**
  - Input transfer: s_valid && s_ready. Output transfer: m_valid && m_ready.
  - s_ready = RUN && in_bits_left ≠ 0 && fill ≤ BUF_W − IN_W. Fully registered; no combinational path from m_ready or s_valid.
  - Push: s_data is written at bit position fill. If a pop happens in the same cycle, it is written at fill − OUT_W instead. fill += IN_W. in_bits_left −= IN_W, saturating at 0.
  - m_valid = RUN && fill ≥ OUT_W && out_left ≠ 0. m_data = buf[OUT_W−1:0], so the lowest bits of the first input word go out first.
  - Pop: buffer shifts right by OUT_W, fill −= OUT_W, out_left −= 1.
  - Simultaneous push and pop in one cycle is legal: fill += IN_W − OUT_W.
  - The pop that takes out_left to 0 moves the FSM to DONE.
- **DONE:** one cycle. done = 1, buffer and fill cleared, so residual bits from the last input word are discarded. Then IDLE.
- start_conv_pulse in RUN or DONE is ignored and the latched config is unchanged.
- Reset asserted mid-frame: immediate return to IDLE, buffer cleared, partial frame lost. No done pulse.
- Bits beyond the frame are never requested: s_ready drops once in_bits_left reaches 0.

## Timing
- Reset values: s_ready 0, m_valid 0, m_data 0, busy 0, done 0, fill 0, FSM IDLE.
- busy = RUN or DONE, registered; it goes high the cycle after start_conv_pulse.
- s_ready is first high the cycle after start_conv_pulse.
- Input-to-output latency: a word accepted at edge t gives m_valid at t+1, once fill ≥ OUT_W.
- Throughput: 1 output word per cycle while upstream keeps fill ≥ OUT_W. Input accepted every cycle while fill ≤ BUF_W − IN_W.
- m_data and m_valid hold stable while m_valid && !m_ready.
- done rises the cycle after the final output transfer. IDLE is reached one cycle later, and a new start is accepted from then.

## Configuration
- IFM_GB_OREG_EN defined:
  - A full-throughput output register slice (2-entry skid) is inserted on m_data/m_valid/m_ready.
  - m_data and m_valid come straight from flops.
  - Latency +1 cycle.
  - DONE waits until the slice is empty.
  - Reset value of the slice is 0/invalid.
- Not defined: outputs are driven directly from the buffer's low bits, as described above.

## Test plan
- **Exact frame.** IN_W=512, OUT_W=80, cfg=32, s_valid constant, m_ready=1.
  - Exactly 5 input transfers, then 32 outputs.
  - Output k = input bits [80k+79 : 80k] of the concatenated stream.
  - One done pulse; busy low 2 cycles after the last output.
- **Residual discard.** cfg=7.
  - 2 input transfers; s_ready low afterwards.
  - 7 outputs, then done; the last 464 bits are dropped.
  - The next frame's first output equals the LSBs of its own first input word.
- **Back-pressure.** m_ready toggled randomly at 50%, s_valid random.
  - No lost or duplicated words; m_data stable while stalled.
  - s_ready low whenever fill > BUF_W − IN_W.
- **Narrow-to-wide ratio.** IN_W=32, OUT_W=80, cfg=4: 10 input words, 4 outputs, correct concatenation across word boundaries.
- **Edge cases.**
  - cfg=0: done one cycle after start, with no s_ready or m_valid.
  - start_conv_pulse during RUN: ignored, frame completes with the original count.
- **Reset mid-frame.** rst_n low after 3 outputs: all outputs 0 immediately, no done pulse. A new frame after reset is correct.
